// File: rtl/ultrasonic_ranger.sv
// ultrasonic_ranger
//   Drives an HC-SR04-style sensor. It issues a trigger pulse, times the echo
//   pulse in microsecond ticks, and converts the width to centimetres with a
//   divide-by-58 counter chain. Results are split into hundreds and the
//   remainder below 100, for the FND digit inputs.
// Ports
//   clk, reset       : system clock, synchronous active-high reset
//   start            : single-cycle measurement request (ignored while busy)
//   auto_en          : level; periodic measurement every PERIOD_MS
//   echo             : asynchronous sensor echo
//   trigger          : sensor trigger pulse
//   digit_h, digit_l : distance / 100 and distance mod 100
//   valid            : one-cycle pulse when the digits take a good result
//   busy             : high whenever the FSM is not idle
//   error            : sticky timeout/saturation flag, cleared by next valid
module ultrasonic_ranger #(
  parameter int CLK_FREQ        = 100_000_000,
  parameter int TRIG_US         = 10,
  parameter int PERIOD_MS       = 60,
  parameter int WAIT_TIMEOUT_US = 25000,
  parameter int MAX_CM          = 400
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       auto_en,
  input  logic       echo,
  output logic       trigger,
  output logic [6:0] digit_h,
  output logic [6:0] digit_l,
  output logic       valid,
  output logic       busy,
  output logic       error
);

  localparam int CLKS_PER_US = CLK_FREQ / 1_000_000;
  localparam int PRE_W       = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;
  localparam int T_MAX       = (WAIT_TIMEOUT_US > TRIG_US) ? WAIT_TIMEOUT_US : TRIG_US;
  localparam int T_W         = $clog2(T_MAX + 1);
  localparam int PER_CYC     = PERIOD_MS * 1000 * CLKS_PER_US;
  localparam int PER_W       = $clog2(PER_CYC + 1);

  localparam logic [PRE_W-1:0] PRE_TC  = PRE_W'(CLKS_PER_US - 1);
  localparam logic [T_W-1:0]   TRIG_TC = T_W'(TRIG_US - 1);
  localparam logic [T_W-1:0]   WAIT_TC = T_W'(WAIT_TIMEOUT_US - 1);
  localparam logic [T_W-1:0]   T_SAT   = T_W'(T_MAX);
  localparam logic [PER_W-1:0] PER_TC  = PER_W'(PER_CYC - 1);
  localparam logic [6:0]       MAX_H   = 7'(MAX_CM / 100);
  localparam logic [6:0]       MAX_L   = 7'(MAX_CM % 100);

  typedef enum logic [2:0] {IDLE, TRIG, WAIT_ECHO, MEASURE, DONE, HOLDOFF} state_t;

  state_t           state_q, state_d;
  logic             echo_s1_q, echo_s2_q, echo_d_q;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [T_W-1:0]   tcnt_q, tcnt_d;
  logic [PER_W-1:0] per_q, per_d;
  logic [5:0]       div_q, div_d;
  logic [6:0]       lo_q, lo_d, hi_q, hi_d;
  logic [6:0]       dh_q, dh_d, dl_q, dl_d;
  logic             valid_q, valid_d, err_q, err_d;
  logic             us_tick, echo_rise, echo_fall;

  assign us_tick   = (pre_q == PRE_TC);
  assign echo_rise = echo_s2_q & ~echo_d_q;
  assign echo_fall = ~echo_s2_q & echo_d_q;

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    dh_d    = dh_q;
    dl_d    = dl_q;
    err_d   = err_q;
    valid_d = 1'b0;

    unique case (state_q)
      IDLE:
        if (start || (auto_en && per_q == PER_TC)) state_d = TRIG;
      TRIG:
        if (us_tick && tcnt_q == TRIG_TC) state_d = WAIT_ECHO;
      WAIT_ECHO: begin
        if (echo_rise) begin
          state_d = MEASURE;
          div_d   = '0;
          lo_d    = '0;
          hi_d    = '0;
        end else if (us_tick && tcnt_q == WAIT_TC) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end
      end
      MEASURE: begin
        // Saturation wins over a coincident fall so MAX_CM is never reported
        // as a good measurement. Digits/valid are loaded on the edge into
        // DONE/HOLDOFF so valid and the new digits appear together.
        if (hi_q == MAX_H && lo_q == MAX_L) begin
          state_d = HOLDOFF;
          dh_d    = MAX_H;
          dl_d    = MAX_L;
          err_d   = 1'b1;
        end else if (echo_fall) begin
          state_d = DONE;
          dh_d    = hi_q;
          dl_d    = lo_q;
          valid_d = 1'b1;
          err_d   = 1'b0;
        end else if (us_tick && echo_s2_q) begin
          // 58 us of echo per cm; lo/hi form a base-100 cm counter.
          if (div_q == 6'd57) begin
            div_d = '0;
            if (lo_q == 7'd99) begin
              lo_d = '0;
              hi_d = hi_q + 7'd1;
            end else begin
              lo_d = lo_q + 7'd1;
            end
          end else begin
            div_d = div_q + 6'd1;
          end
        end
      end
      DONE:    state_d = IDLE;
      HOLDOFF: if (!echo_s2_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Prescaler and tick counter restart on every state change.
    if (state_d != state_q) begin
      pre_d  = '0;
      tcnt_d = '0;
    end else begin
      pre_d  = us_tick ? '0 : pre_q + PRE_W'(1);
      tcnt_d = (us_tick && tcnt_q != T_SAT) ? tcnt_q + T_W'(1) : tcnt_q;
    end

    // The period is counted in raw cycles (PERIOD_MS*1000 ticks worth) so the
    // interval between triggers is exact even though the state prescaler is
    // cleared mid-tick on transitions.
    if (!auto_en)
      per_d = '0;
    else if (state_d == TRIG && state_q != TRIG)
      per_d = '0;
    else if (per_q != PER_TC)
      per_d = per_q + PER_W'(1);
    else
      per_d = per_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      echo_s1_q <= 1'b0;
      echo_s2_q <= 1'b0;
      echo_d_q  <= 1'b0;
      pre_q     <= '0;
      tcnt_q    <= '0;
      per_q     <= '0;
      div_q     <= '0;
      lo_q      <= '0;
      hi_q      <= '0;
      dh_q      <= '0;
      dl_q      <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      echo_s1_q <= echo;
      echo_s2_q <= echo_s1_q;
      echo_d_q  <= echo_s2_q;
      pre_q     <= pre_d;
      tcnt_q    <= tcnt_d;
      per_q     <= per_d;
      div_q     <= div_d;
      lo_q      <= lo_d;
      hi_q      <= hi_d;
      dh_q      <= dh_d;
      dl_q      <= dl_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
    end
  end

  assign trigger = (state_q == TRIG);
  assign busy    = (state_q != IDLE);
  assign digit_h = dh_q;
  assign digit_l = dl_q;
  assign valid   = valid_q;
  assign error   = err_q;

endmodule

// File: tb/tb_ultrasonic_ranger.sv
// Bench for ultrasonic_ranger, scaled down (2 clocks per us, short timeout,
// 2 ms period, MAX_CM=120) so every scenario fits in a short run. Echo widths
// are chosen as 58*cm + offset with offset well inside the bin, so the
// expected cm is simply echo_us/58.
module tb_ultrasonic_ranger;
  localparam int CLK_FREQ = 2_000_000;
  localparam int CPU      = CLK_FREQ / 1_000_000;
  localparam int TRIG_US  = 10;
  localparam int PERIOD_MS = 2;
  localparam int WAIT_US  = 1000;
  localparam int MAX_CM   = 120;
  localparam int PERIOD_CYC = PERIOD_MS * 1000 * CPU;

  logic clk = 1'b0;
  logic reset, start, auto_en, echo;
  logic trigger, valid, busy, error;
  logic [6:0] digit_h, digit_l;

  int n_cmp = 0;
  int n_bad = 0;
  int vtotal = 0;
  int cyc = 0;

  ultrasonic_ranger #(
    .CLK_FREQ(CLK_FREQ), .TRIG_US(TRIG_US), .PERIOD_MS(PERIOD_MS),
    .WAIT_TIMEOUT_US(WAIT_US), .MAX_CM(MAX_CM)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .auto_en(auto_en), .echo(echo),
    .trigger(trigger), .digit_h(digit_h), .digit_l(digit_l),
    .valid(valid), .busy(busy), .error(error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (valid === 1'b1) vtotal <= vtotal + 1;

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string nm);
    int k = 0;
    while (busy !== 1'b0 && k < 50000) begin k++; tick(1); end
    chk({nm, " idle"}, busy, 0);
  endtask

  // One full measurement; echo_us == 0 means the echo never rises.
  task automatic run_meas(input int echo_us, input int eh, input int el,
                          input int eerr, input int ev, input string nm);
    int n, v0;
    v0 = vtotal;
    start = 1'b1; tick(1); start = 1'b0;
    chk({nm, " busy"}, busy, 1);
    n = 0;
    while (trigger === 1'b1 && n < 1000) begin n++; tick(1); end
    chk({nm, " trig_width"}, n, TRIG_US * CPU);
    tick(3);
    if (echo_us > 0) begin
      echo = 1'b1;
      tick(echo_us * CPU);
      chk({nm, " busy_at_fall"}, busy, 1);
      echo = 1'b0;
    end
    wait_idle(nm);
    tick(2);
    chk({nm, " digit_h"}, digit_h, eh);
    chk({nm, " digit_l"}, digit_l, el);
    chk({nm, " error"}, error, eerr);
    chk({nm, " valid_cnt"}, vtotal - v0, ev);
  endtask

  typedef struct {
    int echo_us;
    int eh;
    int el;
    int eerr;
    int ev;
  } vec_t;

  initial begin
    vec_t vt[7];
    int m_h, m_l, m_err, ev, us, cm, v0, k;
    int rise[3];

    vt[0] = '{590,  0, 10, 0, 1};
    vt[1] = '{0,    0, 10, 1, 0};   // timeout: digits held
    vt[2] = '{1200, 0, 20, 0, 1};   // good result clears error
    vt[3] = '{5829, 1, 0,  0, 1};   // lo wraps into hundreds
    vt[4] = '{7000, 1, 20, 1, 0};   // saturates at MAX_CM
    vt[5] = '{1000, 0, 17, 0, 1};
    vt[6] = '{30,   0, 0,  0, 1};

    reset = 1'b1; start = 1'b0; auto_en = 1'b0; echo = 1'b0;
    tick(3);
    chk("rst trigger", trigger, 0);
    chk("rst digit_h", digit_h, 0);
    chk("rst digit_l", digit_l, 0);
    chk("rst valid", valid, 0);
    chk("rst busy", busy, 0);
    chk("rst error", error, 0);
    reset = 1'b0;
    tick(2);

    for (int i = 0; i < 7; i++)
      run_meas(vt[i].echo_us, vt[i].eh, vt[i].el, vt[i].eerr, vt[i].ev,
               $sformatf("vec%0d", i));

    // Randomised measurements against a reference model.
    m_h = vt[6].eh; m_l = vt[6].el; m_err = vt[6].eerr;
    for (int i = 0; i < 5; i++) begin
      if ($urandom_range(0, 4) == 0) us = 0;
      else us = 58 * int'($urandom_range(0, 12)) + int'($urandom_range(5, 52));
      if (us == 0) begin
        m_err = 1; ev = 0;
      end else begin
        cm = us / 58;
        if (cm >= MAX_CM) begin
          m_h = MAX_CM / 100; m_l = MAX_CM % 100; m_err = 1; ev = 0;
        end else begin
          m_h = cm / 100; m_l = cm % 100; m_err = 0; ev = 1;
        end
      end
      run_meas(us, m_h, m_l, m_err, ev, $sformatf("rand%0d_us%0d", i, us));
    end

    // Echo already high when WAIT_ECHO is entered: must time out.
    v0 = vtotal;
    start = 1'b1; tick(1); start = 1'b0;
    tick(2);
    echo = 1'b1;
    wait_idle("prehigh");
    tick(2);
    chk("prehigh error", error, 1);
    chk("prehigh valid_cnt", vtotal - v0, 0);
    chk("prehigh digit_h", digit_h, m_h);
    chk("prehigh digit_l", digit_l, m_l);
    echo = 1'b0;
    tick(5);

    // Auto mode: triggers exactly one period apart; a start mid-echo is ignored.
    v0 = vtotal;
    auto_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      k = 0;
      while (trigger !== 1'b1 && k < 10000) begin k++; tick(1); end
      chk($sformatf("auto trig%0d seen", i), trigger, 1);
      rise[i] = cyc;
      k = 0;
      while (trigger === 1'b1 && k < 1000) begin k++; tick(1); end
      tick(3);
      echo = 1'b1;
      if (i == 1) begin
        tick(300);
        start = 1'b1; tick(1); start = 1'b0;
        tick(590 * CPU - 301);
      end else begin
        tick(590 * CPU);
      end
      echo = 1'b0;
      wait_idle($sformatf("auto%0d", i));
    end
    auto_en = 1'b0;
    tick(5);
    chk("auto spacing01", rise[1] - rise[0], PERIOD_CYC);
    chk("auto spacing12", rise[2] - rise[1], PERIOD_CYC);
    chk("auto valid_cnt", vtotal - v0, 3);
    chk("auto digit_h", digit_h, 0);
    chk("auto digit_l", digit_l, 10);
    chk("auto error", error, 0);

    // Reset during TRIG drops trigger on the next edge.
    start = 1'b1; tick(1); start = 1'b0;
    tick(5);
    reset = 1'b1; tick(1);
    chk("rst_trig trigger", trigger, 0);
    chk("rst_trig busy", busy, 0);
    reset = 1'b0;
    tick(3);

    // Reset during MEASURE clears everything.
    start = 1'b1; tick(1); start = 1'b0;
    tick(TRIG_US * CPU + 3);
    echo = 1'b1;
    tick(400);
    chk("rst_meas pre busy", busy, 1);
    reset = 1'b1; tick(1);
    chk("rst_meas trigger", trigger, 0);
    chk("rst_meas busy", busy, 0);
    chk("rst_meas digit_h", digit_h, 0);
    chk("rst_meas digit_l", digit_l, 0);
    chk("rst_meas error", error, 0);
    reset = 1'b0;
    echo = 1'b0;
    tick(10);
    chk("rst_meas stays idle", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
